// File: rtl/am_insert_tx.sv
// am_insert_tx: 40GBASE-R transmit-side alignment marker inserter.
// Once every AM_GAP data blocks per lane, one alignment marker block goes out
// on all lanes at once. Each marker carries the lane marker bytes and the
// lane's BIP3/BIP7.
// Build option: define AM_BIP_EN to compute per-lane BIP. Without it, every
// marker carries BIP3=0x00 and BIP7=0xFF.
module am_insert_tx #(
    parameter int unsigned LANE_N  = 4,
    parameter int unsigned BLOCK_W = 66,
    parameter int unsigned AM_GAP  = 16383
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    input  logic [LANE_N*BLOCK_W-1:0] block_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [LANE_N*BLOCK_W-1:0] block_o,
    output logic                      am_o
);
    localparam int unsigned BUS_W    = LANE_N * BLOCK_W;
    localparam int unsigned BIP_W    = 8;
    localparam int unsigned CNT_W    = (AM_GAP > 1) ? $clog2(AM_GAP) : 1;
    localparam int unsigned MARKER_N = 4;
    // Marker bytes per lane, packed as {M2, M1, M0}.
    localparam logic [23:0] MARKER_TBL [MARKER_N] = '{
        24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2
    };

    localparam logic [0:0] S_AM   = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    // Reject configurations that have no marker defined or no 66-bit block.
    if (LANE_N > MARKER_N) begin : g_bad_lane_n
        $error("am_insert_tx: no alignment marker defined beyond lane %0d", MARKER_N - 1);
    end
    if (BLOCK_W != 66) begin : g_bad_block_w
        $error("am_insert_tx: BLOCK_W must be 66");
    end

    // BIP3 fold of one block. Payload bit j+2 goes to BIP bit j%8.
    // Sync-header bits 0 and 1 go to BIP bits 3 and 4.
    function automatic logic [BIP_W-1:0] bip_fold(input logic [BLOCK_W-1:0] blk);
        logic [BIP_W-1:0] r;
        r = '0;
        for (int j = 0; j < int'(BLOCK_W) - 2; j++) begin
            r[3'(j)] = r[3'(j)] ^ blk[j + 2];
        end
        r[3] = r[3] ^ blk[0];
        r[4] = r[4] ^ blk[1];
        return r;
    endfunction

    // Marker block for one lane: sync header 01, M0..M2, BIP3, then the
    // complemented copies.
    function automatic logic [BLOCK_W-1:0] am_block(input logic [23:0] m,
                                                    input logic [BIP_W-1:0] bip);
        return {~bip, ~m[23:16], ~m[15:8], ~m[7:0], bip, m, 2'b01};
    endfunction

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    am_q, am_d;
    logic [BUS_W-1:0]        block_q, block_d;
    logic [LANE_N*BIP_W-1:0] lane_bip;
    logic [BUS_W-1:0]        am_bus;
    logic                    xfer;
    logic                    last_blk;

    assign ready_o  = (state_q == S_DATA);
    assign xfer     = valid_i & ready_o;
    assign last_blk = (cnt_q == CNT_W'(AM_GAP - 1));

    assign valid_o  = valid_q;
    assign am_o     = am_q;
    assign block_o  = block_q;

    // Marker blocks for all lanes, built from the current BIP accumulators.
    always_comb begin
        am_bus = '0;
        for (int x = 0; x < int'(LANE_N); x++) begin
            am_bus[x*BLOCK_W +: BLOCK_W] = am_block(MARKER_TBL[x], lane_bip[x*BIP_W +: BIP_W]);
        end
    end

`ifdef AM_BIP_EN
    logic [LANE_N*BIP_W-1:0] bip_q, bip_d;

    // After a marker goes out, reload the accumulator with that marker's fold.
    // Otherwise fold in every accepted data block.
    always_comb begin
        bip_d = bip_q;
        for (int x = 0; x < int'(LANE_N); x++) begin
            if (state_q == S_AM) begin
                bip_d[x*BIP_W +: BIP_W] = bip_fold(am_bus[x*BLOCK_W +: BLOCK_W]);
            end else if (xfer) begin
                bip_d[x*BIP_W +: BIP_W] = bip_q[x*BIP_W +: BIP_W]
                                        ^ bip_fold(block_i[x*BLOCK_W +: BLOCK_W]);
            end
        end
    end

    // BIP accumulator register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) bip_q <= '0;
        else         bip_q <= bip_d;
    end

    assign lane_bip = bip_q;
`else
    assign lane_bip = '0;
`endif

    // Next state: a marker cycle, then AM_GAP accepted data blocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        am_d    = 1'b0;
        block_d = block_q;
        case (state_q)
            S_AM: begin
                valid_d = 1'b1;
                am_d    = 1'b1;
                block_d = am_bus;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    valid_d = 1'b1;
                    block_d = block_i;
                    if (last_blk) begin
                        cnt_d   = '0;
                        state_d = S_AM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_AM;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_AM;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            am_q    <= 1'b0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            am_q    <= am_d;
            block_q <= block_d;
        end
    end
endmodule

// File: tb/tb_am_insert_tx.sv
// tb_am_insert_tx: directed bench for am_insert_tx with AM_GAP=4.
// Expected BIP values follow AM_BIP_EN when the bench is compiled.
module tb_am_insert_tx;
    localparam int unsigned LANE_N  = 4;
    localparam int unsigned BLOCK_W = 66;
    localparam int unsigned AM_GAP  = 4;
    localparam int unsigned BUS_W   = LANE_N * BLOCK_W;

    logic             clk     = 1'b0;
    logic             nreset  = 1'b1;
    logic             valid_i = 1'b0;
    logic [BUS_W-1:0] block_i = '0;
    logic             ready_o;
    logic             valid_o;
    logic             am_o;
    logic [BUS_W-1:0] block_o;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [7:0]       mbip [LANE_N];
    logic [BUS_W-1:0] last_blk;
    logic [65:0]      am1_lane0;

    always #5 clk = ~clk;

    am_insert_tx #(
        .LANE_N (LANE_N),
        .BLOCK_W(BLOCK_W),
        .AM_GAP (AM_GAP)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .valid_i(valid_i),
        .block_i(block_i),
        .ready_o(ready_o),
        .valid_o(valid_o),
        .block_o(block_o),
        .am_o   (am_o)
    );

    // Reference BIP3 of one block, bit by bit from the position table.
    function automatic logic [7:0] ref_bip(input logic [65:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int p = 0; p < 66; p++) begin
            int k;
            if (p == 0)      k = 3;
            else if (p == 1) k = 4;
            else             k = (p - 2) % 8;
            r[k] = r[k] ^ b[p];
        end
        return r;
    endfunction

    function automatic logic [23:0] marker(input int x);
        case (x)
            0:       return {8'h47, 8'h76, 8'h90};
            1:       return {8'hE6, 8'hC4, 8'hF0};
            2:       return {8'h9B, 8'h65, 8'hC5};
            default: return {8'h3D, 8'h79, 8'hA2};
        endcase
    endfunction

    function automatic logic [65:0] ref_am(input int x, input logic [7:0] bip);
        logic [23:0] m;
        m = marker(x);
        return {~bip, ~m[23:16], ~m[15:8], ~m[7:0], bip, m[23:16], m[15:8], m[7:0], 2'b01};
    endfunction

    function automatic logic [BUS_W-1:0] ref_am_bus();
        logic [BUS_W-1:0] v;
        v = '0;
        for (int x = 0; x < int'(LANE_N); x++) v[x*BLOCK_W +: BLOCK_W] = ref_am(x, mbip[x]);
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] v;
        for (int i = 0; i < int'(BUS_W); i++) v[i] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_xfer(input logic [BUS_W-1:0] d, input string tag);
        valid_i = 1'b1;
        block_i = d;
        chk1({tag, "_ready"}, ready_o, 1'b1);
        tick();
        chk1({tag, "_valid"}, valid_o, 1'b1);
        chk1({tag, "_am"}, am_o, 1'b0);
        chkb({tag, "_data"}, block_o, d);
        last_blk = d;
`ifdef AM_BIP_EN
        for (int x = 0; x < int'(LANE_N); x++) mbip[x] = mbip[x] ^ ref_bip(d[x*BLOCK_W +: BLOCK_W]);
`endif
    endtask

    task automatic do_idle(input string tag);
        valid_i = 1'b0;
        block_i = rand_bus();
        chk1({tag, "_ready"}, ready_o, 1'b1);
        tick();
        chk1({tag, "_valid"}, valid_o, 1'b0);
        chk1({tag, "_am"}, am_o, 1'b0);
        chkb({tag, "_hold"}, block_o, last_blk);
    endtask

    // The marker cycle. Upstream keeps offering junk, which must be ignored.
    task automatic do_am(input string tag);
        logic [BUS_W-1:0] exp;
        valid_i = 1'b1;
        block_i = rand_bus();
        chk1({tag, "_ready"}, ready_o, 1'b0);
        exp = ref_am_bus();
        tick();
        chk1({tag, "_valid"}, valid_o, 1'b1);
        chk1({tag, "_am"}, am_o, 1'b1);
        chkb({tag, "_block"}, block_o, exp);
        last_blk = exp;
`ifdef AM_BIP_EN
        for (int x = 0; x < int'(LANE_N); x++) mbip[x] = ref_bip(exp[x*BLOCK_W +: BLOCK_W]);
`endif
    endtask

    initial begin
        for (int x = 0; x < int'(LANE_N); x++) mbip[x] = 8'h00;
        am1_lane0 = {8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01};

        // Reset: all outputs low, no acceptance.
        #2 nreset = 1'b0;
        #1;
        chk1("rst_valid", valid_o, 1'b0);
        chk1("rst_am", am_o, 1'b0);
        chkb("rst_block", block_o, '0);
        chk1("rst_ready", ready_o, 1'b0);
        valid_i = 1'b1;
        block_i = rand_bus();
        tick();
        tick();
        chk1("rst_hold_valid", valid_o, 1'b0);
        nreset = 1'b1;

        // First output after reset is a marker with BIP3=0x00.
        do_am("am1");
        chkb("am1_lane0_const", BUS_W'(block_o[65:0]), BUS_W'(am1_lane0));

        // Continuous traffic: exactly AM_GAP data blocks, then a marker.
        for (int i = 0; i < int'(AM_GAP); i++) do_xfer(rand_bus(), $sformatf("cont%0d", i));
        do_am("am2");

        // Idle cycles do not advance the gap counter.
        do_xfer(rand_bus(), "tog0");
        do_idle("idle0");
        do_xfer(rand_bus(), "tog1");
        do_idle("idle1");
        do_xfer(rand_bus(), "tog2");
        do_idle("idle2");
        do_xfer(rand_bus(), "tog3");
        do_am("am3");

        // All-zero data: the next BIP3 is the fold of the previous marker alone.
        for (int i = 0; i < int'(AM_GAP); i++) do_xfer('0, $sformatf("zero%0d", i));
        do_am("am4");
`ifdef AM_BIP_EN
        chkb("am4_lane0_bip3", BUS_W'(block_o[33:26]), BUS_W'(8'h08));
        chkb("am4_lane0_bip7", BUS_W'(block_o[65:58]), BUS_W'(8'hF7));
        chkb("am4_lane2_bip3", BUS_W'(block_o[2*66+26 +: 8]), BUS_W'(8'h08));
`else
        chkb("am4_lane0_bip3", BUS_W'(block_o[33:26]), BUS_W'(8'h00));
        chkb("am4_lane0_bip7", BUS_W'(block_o[65:58]), BUS_W'(8'hFF));
        chkb("am4_lane2_bip3", BUS_W'(block_o[2*66+26 +: 8]), BUS_W'(8'h00));
`endif

        // Reset mid-period (counter=2): outputs clear at once, then a fresh marker.
        do_xfer(rand_bus(), "mid0");
        do_xfer(rand_bus(), "mid1");
        #2 nreset = 1'b0;
        #1;
        chk1("midrst_valid", valid_o, 1'b0);
        chk1("midrst_am", am_o, 1'b0);
        chkb("midrst_block", block_o, '0);
        chk1("midrst_ready", ready_o, 1'b0);
        for (int x = 0; x < int'(LANE_N); x++) mbip[x] = 8'h00;
        tick();
        nreset = 1'b1;
        do_am("am5");
        chkb("am5_lane0_const", BUS_W'(block_o[65:0]), BUS_W'(am1_lane0));

        // One more full period after the reset.
        for (int i = 0; i < int'(AM_GAP); i++) do_xfer(rand_bus(), $sformatf("post%0d", i));
        do_am("am6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
